// File: rtl/scene_loader_mseg.sv
// scene_loader_mseg: packs xmodem bytes into SDRAM words across length-prefixed segments
// with block checkpointing; define LOADER_LE_EN for little-endian packing.
module scene_loader_mseg #(
    parameter int NUM_SEGS = 4,
    parameter int ADDR_W = 25,
    parameter int WORD_BYTES = 4,
    parameter int BLOCK_BYTES = 128,
    parameter logic [NUM_SEGS*ADDR_W-1:0] SEG_BASE = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic [7:0] byte_in,
    input  logic byte_valid,
    input  logic blk_good,
    input  logic blk_bad,
    input  logic blk_repeat,
    input  logic xfer_done,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [8*WORD_BYTES-1:0] wr_data,
    output logic wr_valid,
    input  logic wr_ready,
    output logic [(NUM_SEGS > 1 ? $clog2(NUM_SEGS) : 1)-1:0] seg_idx,
    output logic done,
    output logic overrun
);
    localparam int SEG_W = NUM_SEGS > 1 ? $clog2(NUM_SEGS) : 1;
    localparam int BP_W = $clog2(WORD_BYTES);
    localparam int DW = 8 * WORD_BYTES;

    if (NUM_SEGS < 1 || WORD_BYTES < 2 || BLOCK_BYTES % WORD_BYTES != 0) begin : g_bad_cfg
        $error("scene_loader_mseg: invalid parameter set");
    end

    typedef enum logic {PH_SIZE, PH_DATA} phase_t;
    typedef struct packed {
        phase_t phase;
        logic [SEG_W-1:0] seg;
        logic [ADDR_W-1:0] size;
        logic [ADDR_W-1:0] offset;
        logic [BP_W-1:0] bphase;
    } st_t;

    st_t st, st_n, ckpt, ckpt_n;
    logic rep, rep_n, done_n, overrun_n, wr_valid_n;
    logic [DW-9:0] acc, acc_n;
    logic [DW-1:0] word, wr_data_n;
    logic [ADDR_W-1:0] wr_addr_n, size_w;
    logic [SEG_W-1:0] seg_next;
    logic restore, save, take, complete, accept, last;
    logic [ADDR_W-1:0] base [NUM_SEGS];

    for (genvar i = 0; i < NUM_SEGS; i++) begin : g_base
        assign base[i] = SEG_BASE[i*ADDR_W +: ADDR_W];
    end

`ifdef LOADER_LE_EN
    assign word = {byte_in, acc};
    assign acc_n = take ? word[DW-1:8] : acc;
`else
    assign word = {acc, byte_in};
    assign acc_n = take ? word[DW-9:0] : acc;
`endif

    assign size_w = ADDR_W'(word);
    assign restore = blk_bad | (blk_good & rep);
    assign save = blk_good & ~rep;
    // restore wins over a byte arriving in the same cycle
    assign take = byte_valid & ~done & ~restore;
    assign complete = take & (st.bphase == BP_W'(WORD_BYTES - 1));
    assign accept = wr_valid & wr_ready;
    assign last = (st.offset + ADDR_W'(1)) == st.size;
    assign seg_next = (st.seg == SEG_W'(NUM_SEGS - 1)) ? '0 : st.seg + SEG_W'(1);
    assign seg_idx = st.seg;

    always_comb begin
        st_n = st;
        rep_n = blk_repeat ? 1'b1 : blk_good ? 1'b0 : rep;
        done_n = done | xfer_done;
        overrun_n = overrun;
        wr_valid_n = wr_valid & ~accept;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        if (restore) begin
            st_n = ckpt;
            wr_valid_n = 1'b0;
        end else if (take) begin
            st_n.bphase = complete ? '0 : st.bphase + BP_W'(1);
            if (complete && st.phase == PH_SIZE) begin
                st_n.size = size_w;
                st_n.offset = '0;
                st_n.phase = (size_w == '0) ? PH_SIZE : PH_DATA;
                st_n.seg = (size_w == '0) ? seg_next : st.seg;
            end else if (complete) begin
                st_n.offset = last ? '0 : st.offset + ADDR_W'(1);
                st_n.seg = last ? seg_next : st.seg;
                st_n.phase = last ? PH_SIZE : PH_DATA;
                // a word that finds the buffer still owned by the arbiter is dropped
                if (wr_valid && !accept) begin
                    overrun_n = 1'b1;
                end else begin
                    wr_valid_n = 1'b1;
                    wr_addr_n = base[st.seg] + st.offset;
                    wr_data_n = word;
                end
            end
        end
        ckpt_n = save ? st_n : ckpt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= '0;
            ckpt <= '0;
            rep <= 1'b0;
            acc <= '0;
            done <= 1'b0;
            overrun <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            st <= st_n;
            ckpt <= ckpt_n;
            rep <= rep_n;
            acc <= acc_n;
            done <= done_n;
            overrun <= overrun_n;
            wr_valid <= wr_valid_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
        end
    end
endmodule
